vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator. It is the next generation of the videocard's fixed 640×480 control-line logic. It derives a pixel-rate enable from the system clock and runs horizontal and vertical counters through active, front-porch, sync and back-porch regions. From these it produces sync pulses with programmable polarity, a data-enable, pixel coordinates, and line/frame start strobes. It sits between the on-chip oscillator clock and the pixel/colour generation logic in the top level.

## Interface
- `CNT_W`, 11: width of the counters and of `x`/`y`.
- `PIX_DIV`, 2: system clocks per pixel (≥1).
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, 640/16/96/48: horizontal region lengths in pixels (each ≥1).
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, 480/10/2/33: vertical region lengths in lines (each ≥1).
- `HS_POL`, `VS_POL`, 0/0: asserted level of `h_sync`/`v_sync`.
- `clk`  in  1  system clock; single clock domain.
- `RESET`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; low freezes all state.
- `pix_ce`  out  1  one-clk pulse marking a new pixel on `x`/`y`.
- `h_sync`  out  1  horizontal sync at `HS_POL`.
- `v_sync`  out  1  vertical sync at `VS_POL`.
- `de`  out  1  active-video data enable.
- `x`  out  CNT_W  horizontal count, 0..H_TOTAL-1.
- `y`  out  CNT_W  vertical count, 0..V_TOTAL-1.
- `line_start`  out  1  one-clk pulse at x=0.
- `frame_start`  out  1  one-clk pulse at x=0, y=0.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Region order on each axis: active, front porch, sync, back porch.
- Divider `div` counts 0..PIX_DIV-1 while `en`=1. A step occurs on the edge where `en`=1 and `div`=PIX_DIV-1; on that edge `div` returns to 0.
- On a step:
  - `h_cnt` increments, wrapping H_TOTAL-1→0.
  - On that wrap, `v_cnt` increments, wrapping V_TOTAL-1→0.
- Decode of the new counter values:
  - `h_sync` = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. `v_sync` is decoded the same way on `v` with `VS_POL`.
  - `de` = (h<H_ACTIVE) && (v<V_ACTIVE).
  - `x`=h, `y`=v.
- `pix_ce`, `line_start`, `frame_start` are high only for the single clk following a step. `line_start` requires new h=0. `frame_start` requires new h=0 and v=0.
- Between steps, `h_sync`/`v_sync`/`de`/`x`/`y` hold and the strobes are 0.
- `en`=0: divider, counters and all level outputs hold; `pix_ce` and the strobes are 0. Resuming continues from the held `div`.
- Counter arithmetic is unsigned and never exceeds TOTAL-1. Elaboration must fail if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W, or if any parameter is <1.

## Timing
- Every output is a flop; no combinational path from `en` to any output.
- Reset values:
  - Internal: `div`=0, `h_cnt`=H_TOTAL-1, `v_cnt`=V_TOTAL-1, so the first step lands on (0,0).
  - Outputs: `x`=`y`=0, `de`=0, `h_sync`=~HS_POL, `v_sync`=~VS_POL, `pix_ce`=`line_start`=`frame_start`=0.
- First step occurs on the PIX_DIV-th edge after `RESET` is released with `en`=1.
- Zero latency between counters and outputs: outputs are decoded from next-state values, so `x`/`y`/`de`/syncs are coherent within the same cycle.
- PIX_DIV=1: a step occurs every clk with `en`=1, and `pix_ce` stays high continuously.
- `RESET` has priority over `en`. A reset mid-frame takes effect on the next edge; the raster restarts at (0,0) with `frame_start`.

## Structure
- Package `vga_timing_pkg` holds:
  - the default 640×480@60 constants;
  - `CNT_W`;
  - a total/sync-window helper function.
- Sub-module `vga_axis_counter` is instantiated twice, once per axis. Each instance provides:
  - counter, wrap output and increment input;
  - reset-to-last value;
  - active/sync decode and polarity.
- The top level contains only the divider, strobe generation and `en` gating.

## Test plan
- Defaults: `RESET` held 4 clk, `en`=1.
  - First edge after release: outputs remain at reset values.
  - Second edge: `x`=0, `y`=0, `de`=1, `pix_ce`=`line_start`=`frame_start`=1 for exactly 1 clk.
- Defaults, line timing:
  - `de` high for 640 steps.
  - `h_sync`=0 exactly for x=656..751.
  - `line_start` period is 800 steps = 1600 clk.
- Defaults, frame timing:
  - `v_sync`=0 for y=490..491 only.
  - `de`=0 whenever y≥480.
  - `frame_start` period is 420000 steps = 840000 clk.
- PIX_DIV=1, HS_POL=VS_POL=1, H=8/2/2/2, V=4/1/1/1:
  - `pix_ce` constantly 1.
  - `h_sync`=1 at x=10..11.
  - Line of 14 clk; frame of 98 clk.
- `en` dropped at x=100:
  - all outputs hold and `pix_ce`=0 for 50 clk;
  - after `en` returns, the next step gives x=101 with `div` resuming.
- `RESET` pulsed 1 clk at y=300:
  - outputs at reset values on the next cycle;
  - after PIX_DIV edges, (0,0) with `frame_start`=1.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 2:1 system-to-pixel clock ratio.
package vga_timing_pkg;

    localparam int unsigned DEF_CNT_W    = 11;
    localparam int unsigned DEF_PIX_DIV  = 2;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam bit DEF_HS_POL = 1'b0;
    localparam bit DEF_VS_POL = 1'b0;

    // Full period of one axis (active + front porch + sync + back porch).
    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    // First count inside the sync window.
    function automatic int unsigned sync_begin(
        input int unsigned active,
        input int unsigned fp
    );
        return active + fp;
    endfunction

    // First count after the sync window (exclusive bound).
    function automatic int unsigned sync_end(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync
    );
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping counter plus decode of its next value into
// active-region and sync-window flags (sync already at its asserted polarity).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter bit          POL    = DEF_HS_POL
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             i_inc,
    output logic             o_wrap,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic             o_active_nxt,
    output logic             o_sync_nxt
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    if (CNT_W < 1 || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_param
        $error("vga_axis_counter: every parameter must be >= 1");
    end
    if (((longint'(TOTAL) - 1) >> CNT_W) != 0) begin : g_bad_width
        $error("vga_axis_counter: TOTAL-1 does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(sync_begin(ACTIVE, FP));
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(sync_end(ACTIVE, FP, SYNC));

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign o_wrap = i_inc && w_last;

    // Next count and its region decode, so the top can register coherent outputs.
    always_comb begin
        o_cnt_nxt = r_cnt;
        if (i_inc) begin
            o_cnt_nxt = w_last ? '0 : r_cnt + CNT_W'(1);
        end
        o_active_nxt = (o_cnt_nxt < ACT_END);
        o_sync_nxt   = ((o_cnt_nxt >= SYNC_BEG) && (o_cnt_nxt < SYNC_END)) ? POL : ~POL;
    end

    // Counter parks on the last count in reset so the first increment lands on 0.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_cnt <= LAST;
        end else begin
            r_cnt <= o_cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, enable gating and
// registered sync/DE/coordinate/strobe outputs driven by two axis counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = DEF_HS_POL,
    parameter bit          VS_POL   = DEF_VS_POL
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    output logic             pix_ce,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    if (PIX_DIV < 1 || CNT_W < 1) begin : g_bad_param
        $error("vga_timing_gen: PIX_DIV and CNT_W must be >= 1");
    end

    localparam int unsigned        DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             w_step;

    logic             w_h_wrap;
    logic [CNT_W-1:0] w_h_nxt;
    logic             w_h_act;
    logic             w_h_sync;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_v_act;
    logic             w_v_sync;

    logic             r_pix_ce;
    logic             r_h_sync;
    logic             r_v_sync;
    logic             r_de;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_line_start;
    logic             r_frame_start;

    assign w_step = en && (r_div == DIV_LAST);

    // Pixel-rate divider; holds its phase while en is low.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_div <= '0;
        end else if (w_step) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .CNT_W  (CNT_W),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_axis (
        .clk          (clk),
        .RESET        (RESET),
        .i_inc        (w_step),
        .o_wrap       (w_h_wrap),
        .o_cnt_nxt    (w_h_nxt),
        .o_active_nxt (w_h_act),
        .o_sync_nxt   (w_h_sync)
    );

    vga_axis_counter #(
        .CNT_W  (CNT_W),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_axis (
        .clk          (clk),
        .RESET        (RESET),
        .i_inc        (w_h_wrap),
        .o_wrap       (w_v_wrap),
        .o_cnt_nxt    (w_v_nxt),
        .o_active_nxt (w_v_act),
        .o_sync_nxt   (w_v_sync)
    );

    // Register outputs from next-state decode; an h wrap is exactly a step to
    // h=0 and a v wrap is exactly a step to (0,0), so they serve as the strobes.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_pix_ce      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_de          <= 1'b0;
            r_h_sync      <= ~HS_POL;
            r_v_sync      <= ~VS_POL;
        end else begin
            r_pix_ce      <= w_step;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
            if (w_step) begin
                r_x      <= w_h_nxt;
                r_y      <= w_v_nxt;
                r_de     <= w_h_act && w_v_act;
                r_h_sync <= w_h_sync;
                r_v_sync <= w_v_sync;
            end
        end
    end

    assign pix_ce      = r_pix_ce;
    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations run side by side against a
// step-count reference model (position = steps since reset, split by totals).
module tb_vga_timing_gen;

    localparam int N    = 3;
    localparam int NCYC = 8000;

    // 0: defaults, 1: tiny PIX_DIV=1 positive-polarity raster, 2: odd mixed config
    localparam int unsigned C_PD [N] = '{2, 1, 3};
    localparam int unsigned C_HA [N] = '{640, 8, 20};
    localparam int unsigned C_HF [N] = '{16, 2, 3};
    localparam int unsigned C_HS [N] = '{96, 2, 4};
    localparam int unsigned C_HB [N] = '{48, 2, 5};
    localparam int unsigned C_VA [N] = '{480, 4, 12};
    localparam int unsigned C_VF [N] = '{10, 1, 2};
    localparam int unsigned C_VS [N] = '{2, 1, 3};
    localparam int unsigned C_VB [N] = '{33, 1, 4};
    localparam bit          C_HP [N] = '{1'b0, 1'b1, 1'b1};
    localparam bit          C_VP [N] = '{1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst [N];
    logic        en  [N];
    logic        pix_ce [N];
    logic        hs [N];
    logic        vs [N];
    logic        de [N];
    logic [10:0] xo [N];
    logic [10:0] yo [N];
    logic        ls [N];
    logic        fs [N];

    int     n_tests = 0;
    int     n_fail  = 0;

    int     m_div  [N];
    longint m_n    [N];
    bit     m_step [N];

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .RESET(rst[0]), .en(en[0]), .pix_ce(pix_ce[0]), .h_sync(hs[0]),
        .v_sync(vs[0]), .de(de[0]), .x(xo[0]), .y(yo[0]), .line_start(ls[0]),
        .frame_start(fs[0])
    );

    vga_timing_gen #(
        .CNT_W(11), .PIX_DIV(C_PD[1]),
        .H_ACTIVE(C_HA[1]), .H_FP(C_HF[1]), .H_SYNC(C_HS[1]), .H_BP(C_HB[1]),
        .V_ACTIVE(C_VA[1]), .V_FP(C_VF[1]), .V_SYNC(C_VS[1]), .V_BP(C_VB[1]),
        .HS_POL(C_HP[1]), .VS_POL(C_VP[1])
    ) u_dut1 (
        .clk(clk), .RESET(rst[1]), .en(en[1]), .pix_ce(pix_ce[1]), .h_sync(hs[1]),
        .v_sync(vs[1]), .de(de[1]), .x(xo[1]), .y(yo[1]), .line_start(ls[1]),
        .frame_start(fs[1])
    );

    vga_timing_gen #(
        .CNT_W(11), .PIX_DIV(C_PD[2]),
        .H_ACTIVE(C_HA[2]), .H_FP(C_HF[2]), .H_SYNC(C_HS[2]), .H_BP(C_HB[2]),
        .V_ACTIVE(C_VA[2]), .V_FP(C_VF[2]), .V_SYNC(C_VS[2]), .V_BP(C_VB[2]),
        .HS_POL(C_HP[2]), .VS_POL(C_VP[2])
    ) u_dut2 (
        .clk(clk), .RESET(rst[2]), .en(en[2]), .pix_ce(pix_ce[2]), .h_sync(hs[2]),
        .v_sync(vs[2]), .de(de[2]), .x(xo[2]), .y(yo[2]), .line_start(ls[2]),
        .frame_start(fs[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint h_total(input int i);
        return longint'(C_HA[i]) + C_HF[i] + C_HS[i] + C_HB[i];
    endfunction

    function automatic longint v_total(input int i);
        return longint'(C_VA[i]) + C_VF[i] + C_VS[i] + C_VB[i];
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge(input int i);
        m_step[i] = 1'b0;
        if (rst[i]) begin
            m_div[i] = 0;
            m_n[i]   = -1;
        end else if (en[i]) begin
            if (m_div[i] == int'(C_PD[i]) - 1) begin
                m_div[i]  = 0;
                m_n[i]    = m_n[i] + 1;
                m_step[i] = 1'b1;
            end else begin
                m_div[i] = m_div[i] + 1;
            end
        end
    endtask

    // Compare every output of instance i with the position implied by m_n.
    task automatic compare(input int i);
        longint h, v, ht, vt, sb, se, vsb, vse;
        bit     run, e_hs, e_vs, e_de, e_ls, e_fs;
        ht  = h_total(i);
        vt  = v_total(i);
        run = (m_n[i] >= 0);
        h   = run ? (m_n[i] % ht) : 0;
        v   = run ? ((m_n[i] / ht) % vt) : 0;
        sb  = longint'(C_HA[i]) + C_HF[i];
        se  = sb + C_HS[i];
        vsb = longint'(C_VA[i]) + C_VF[i];
        vse = vsb + C_VS[i];
        e_hs = (run && h >= sb && h < se) ? C_HP[i] : !C_HP[i];
        e_vs = (run && v >= vsb && v < vse) ? C_VP[i] : !C_VP[i];
        e_de = run && (h < C_HA[i]) && (v < C_VA[i]);
        e_ls = m_step[i] && (h == 0);
        e_fs = e_ls && (v == 0);
        check($sformatf("u%0d.x", i), 64'(xo[i]), 64'(h));
        check($sformatf("u%0d.y", i), 64'(yo[i]), 64'(v));
        check($sformatf("u%0d.de", i), 64'(de[i]), 64'(e_de));
        check($sformatf("u%0d.h_sync", i), 64'(hs[i]), 64'(e_hs));
        check($sformatf("u%0d.v_sync", i), 64'(vs[i]), 64'(e_vs));
        check($sformatf("u%0d.pix_ce", i), 64'(pix_ce[i]), 64'(m_step[i]));
        check($sformatf("u%0d.line_start", i), 64'(ls[i]), 64'(e_ls));
        check($sformatf("u%0d.frame_start", i), 64'(fs[i]), 64'(e_fs));
    endtask

    initial begin
        int     hold;
        bit     dropped;
        bit     pulsed;
        int     last_ls1;
        int     last_fs1;
        int     q_ls0 [$];
        longint y2;

        hold     = 0;
        dropped  = 1'b0;
        pulsed   = 1'b0;
        last_ls1 = -1;
        last_fs1 = -1;
        for (int i = 0; i < N; i++) begin
            rst[i]    = 1'b1;
            en[i]     = 1'b1;
            m_div[i]  = 0;
            m_n[i]    = -1;
            m_step[i] = 1'b0;
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            for (int i = 0; i < N; i++) model_edge(i);
            #1;
            for (int i = 0; i < N; i++) compare(i);

            // Period checks on observed strobes
            if (ls[0] === 1'b1) q_ls0.push_back(cyc);
            if (ls[1] === 1'b1) begin
                if (last_ls1 >= 0) check("u1.line_period", 64'(cyc - last_ls1), 64'(14));
                last_ls1 = cyc;
            end
            if (fs[1] === 1'b1) begin
                if (last_fs1 >= 0) check("u1.frame_period", 64'(cyc - last_fs1), 64'(98));
                last_fs1 = cyc;
            end

            // Stimulus for the next edge
            if (cyc == 3) begin
                for (int i = 0; i < N; i++) rst[i] = 1'b0;
            end

            // Instance 0: drop en for 50 clk just after x becomes 100 on line 1
            if (!dropped && m_step[0] && m_n[0] == 900) begin
                en[0]   = 1'b0;
                hold    = 50;
                dropped = 1'b1;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) en[0] = 1'b1;
            end

            // Instance 2: random en, one directed mid-frame reset, rare random resets
            if (cyc >= 3) begin
                en[2]  = ($urandom_range(0, 3) != 0);
                rst[2] = 1'b0;
                y2 = (m_n[2] >= 0) ? ((m_n[2] / h_total(2)) % v_total(2)) : -1;
                if (!pulsed && m_step[2] && y2 == 7) begin
                    rst[2] = 1'b1;
                    pulsed = 1'b1;
                end else if ($urandom_range(0, 1499) == 0) begin
                    rst[2] = 1'b1;
                end
            end
        end

        // Instance 0 line periods: undisturbed 1600 clk, the en-gap line 1650 clk
        check("u0.line_starts_seen", 64'(q_ls0.size() >= 4), 64'(1));
        if (q_ls0.size() >= 4) begin
            check("u0.line_period0", 64'(q_ls0[1] - q_ls0[0]), 64'(1600));
            check("u0.line_period_en_gap", 64'(q_ls0[2] - q_ls0[1]), 64'(1650));
            check("u0.line_period2", 64'(q_ls0[3] - q_ls0[2]), 64'(1600));
        end
        check("u1.frames_seen", 64'(last_fs1 > 0), 64'(1));
        check("u2.mid_frame_reset_hit", 64'(pulsed), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
